// File: rtl/exec_control_path_if.sv
// rtl/exec_control_path_if.sv - instruction, register-file and result signals of the decode/execute slice

interface exec_control_path_if;
  logic [31:0] instruction;
  logic [7:0]  regout1;
  logic [7:0]  regout2;
  logic [2:0]  readreg1;
  logic [2:0]  readreg2;
  logic [2:0]  writereg;
  logic        writeenable;
  logic [2:0]  aluop;
  logic [7:0]  aluresult;

  // Instruction memory / register file side
  modport master (
    output instruction, regout1, regout2,
    input  readreg1, readreg2, writereg, writeenable, aluop, aluresult
  );

  // Decode/execute slice side
  modport slave (
    input  instruction, regout1, regout2,
    output readreg1, readreg2, writereg, writeenable, aluop, aluresult
  );
endinterface

// File: rtl/exec_control_path.sv
// rtl/exec_control_path.sv - instruction register, control decode, operand muxes, negator and ALU

module exec_control_path (
  input  logic               clk,
  input  logic               reset,  // active-low, asynchronous
  exec_control_path_if.slave bus
);
  logic [31:0] ir;
  logic        valid;

  logic [7:0]  opcode;
  logic [7:0]  immediate;
  logic [2:0]  aluop;
  logic        muxcompselect;
  logic        muximmselect;
  logic        writeenable;
  logic [7:0]  compliment;
  logic [7:0]  comp_mux_out;
  logic [7:0]  opnd;
  logic [7:0]  alu_result;
  logic        unused_ir_bits;

  // Capture one instruction per cycle; reset clears IR so every decoded field reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir    <= 32'h0000_0000;
      valid <= 1'b0;
    end else begin
      ir    <= bus.instruction;
      valid <= 1'b1;
    end
  end

  assign opcode    = ir[31:24];
  assign immediate = ir[7:0];

  // Bits between the register fields carry no meaning for this instruction set
  assign unused_ir_bits = ^{ir[23:19], ir[15:11]};

  exec_control_unit u_control (
    .opcode        (opcode),
    .valid         (valid),
    .aluop         (aluop),
    .muxcompselect (muxcompselect),
    .muximmselect  (muximmselect),
    .writeenable   (writeenable)
  );

  exec_negator u_negator (
    .data_in  (bus.regout2),
    .data_out (compliment)
  );

  exec_mux2to1 u_comp_mux (
    .sel      (muxcompselect),
    .in0      (bus.regout2),
    .in1      (compliment),
    .data_out (comp_mux_out)
  );

  exec_mux2to1 u_imm_mux (
    .sel      (muximmselect),
    .in0      (comp_mux_out),
    .in1      (immediate),
    .data_out (opnd)
  );

  exec_alu u_alu (
    .data1  (bus.regout1),
    .data2  (opnd),
    .aluop  (aluop),
    .result (alu_result)
  );

  assign bus.readreg1    = ir[10:8];
  assign bus.readreg2    = ir[2:0];
  assign bus.writereg    = ir[18:16];
  assign bus.writeenable = writeenable;
  assign bus.aluop       = aluop;
  // Before the first capture after reset the result is held at zero regardless of register data
  assign bus.aluresult   = valid ? alu_result : 8'h00;
endmodule

module exec_control_unit (
  input  logic [7:0] opcode,
  input  logic       valid,
  output logic [2:0] aluop,
  output logic       muxcompselect,
  output logic       muximmselect,
  output logic       writeenable
);
  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FORWARD = 3'b000;
  localparam logic [2:0] ALU_ADD     = 3'b001;
  localparam logic [2:0] ALU_AND     = 3'b010;
  localparam logic [2:0] ALU_OR      = 3'b011;

  // Opcode to control decode; unknown opcodes and the not-yet-valid state are write-free no-ops
  always_comb begin
    aluop         = ALU_FORWARD;
    muxcompselect = 1'b0;
    muximmselect  = 1'b0;
    writeenable   = 1'b0;
    if (valid) begin
      case (opcode)
        OP_LOADI: begin
          muximmselect = 1'b1;
          writeenable  = 1'b1;
        end
        OP_MOV: begin
          writeenable = 1'b1;
        end
        OP_ADD: begin
          aluop       = ALU_ADD;
          writeenable = 1'b1;
        end
        OP_SUB: begin
          aluop         = ALU_ADD;
          muxcompselect = 1'b1;
          writeenable   = 1'b1;
        end
        OP_AND: begin
          aluop       = ALU_AND;
          writeenable = 1'b1;
        end
        OP_OR: begin
          aluop       = ALU_OR;
          writeenable = 1'b1;
        end
        default: begin
          aluop       = ALU_FORWARD;
          writeenable = 1'b0;
        end
      endcase
    end
  end
endmodule

module exec_mux2to1 (
  input  logic       sel,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  output logic [7:0] data_out
);
  assign data_out = sel ? in1 : in0;
endmodule

module exec_negator (
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);
  // Two's complement wraps, so 0x00 and 0x80 map to themselves
  assign data_out = ~data_in + 8'd1;
endmodule

module exec_alu (
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [2:0] aluop,
  output logic [7:0] result
);
  // Carry is dropped; reserved function codes yield zero
  always_comb begin
    result = 8'h00;
    case (aluop)
      3'b000:  result = data2;
      3'b001:  result = data1 + data2;
      3'b010:  result = data1 & data2;
      3'b011:  result = data1 | data2;
      default: result = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_exec_control_path.sv
// tb/tb_exec_control_path.sv - randomized self-checking bench for exec_control_path

module tb_exec_control_path;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  exec_control_path_if bus ();

  exec_control_path dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction-set semantics: what the register file should receive for an instruction
  function automatic void model(input logic [31:0] ins, input logic [7:0] r1, input logic [7:0] r2,
                                output logic we, output logic [2:0] op, output logic [7:0] res);
    int a, b;
    a = r1;
    b = r2;
    we = 1'b1;
    op = 3'd0;
    case (ins[31:24])
      8'h00: res = ins[7:0];
      8'h01: res = r2;
      8'h02: begin op = 3'd1; res = 8'((a + b) % 256); end
      8'h03: begin op = 3'd1; res = 8'((a - b + 256) % 256); end
      8'h04: begin op = 3'd2; res = r1 & r2; end
      8'h05: begin op = 3'd3; res = r1 | r2; end
      default: begin we = 1'b0; res = r2; end
    endcase
  endfunction

  // Present an instruction and land 1 time unit after the capturing edge
  task automatic capture(input logic [31:0] ins);
    @(negedge clk);
    bus.instruction = ins;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.instruction = 32'h0201_0203;
    bus.regout1 = 8'h11;
    bus.regout2 = 8'h22;
    #1;
    checks++;
    if ({bus.readreg1, bus.readreg2, bus.writereg, bus.aluop, bus.writeenable, bus.aluresult} !== 21'd0) begin
      fails++;
      $display("FAIL reset_state: got rr1=%0d rr2=%0d wr=%0d op=%0d we=%0d res=%h, want all 0",
               bus.readreg1, bus.readreg2, bus.writereg, bus.aluop, bus.writeenable, bus.aluresult);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.writeenable, bus.aluresult, bus.writereg} !== 12'd0) begin
      fails++;
      $display("FAIL reset_hold: we=%0d res=%h wr=%0d, want 0", bus.writeenable, bus.aluresult, bus.writereg);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_loadi;
    capture(32'h0004_005A);
    bus.regout1 = 8'h33;
    bus.regout2 = 8'h77;
    #1;
    checks++;
    if ({bus.writeenable, bus.writereg, bus.aluop, bus.aluresult} !== {1'b1, 3'd4, 3'd0, 8'h5A}) begin
      fails++;
      $display("FAIL loadi: we=%0d wr=%0d op=%0d res=%h, want we=1 wr=4 op=0 res=5a",
               bus.writeenable, bus.writereg, bus.aluop, bus.aluresult);
    end
  endtask

  task automatic test_add_sub;
    capture(32'h0201_0203);
    checks++;
    if ({bus.readreg1, bus.readreg2, bus.writereg} !== {3'd2, 3'd3, 3'd1}) begin
      fails++;
      $display("FAIL add_addr: rr1=%0d rr2=%0d wr=%0d, want 2 3 1", bus.readreg1, bus.readreg2, bus.writereg);
    end
    bus.regout1 = 8'h10;
    bus.regout2 = 8'h25;
    #1;
    checks++;
    if (bus.aluresult !== 8'h35) begin
      fails++;
      $display("FAIL add_basic: got %h want 35", bus.aluresult);
    end
    bus.regout1 = 8'hF0;
    bus.regout2 = 8'h20;
    #1;
    checks++;
    if (bus.aluresult !== 8'h10) begin
      fails++;
      $display("FAIL add_wrap: got %h want 10", bus.aluresult);
    end
    capture(32'h0301_0203);
    bus.regout1 = 8'h05;
    bus.regout2 = 8'h07;
    #1;
    checks++;
    if ({bus.aluop, bus.writeenable, bus.aluresult} !== {3'd1, 1'b1, 8'hFE}) begin
      fails++;
      $display("FAIL sub: op=%0d we=%0d res=%h, want op=1 we=1 res=fe", bus.aluop, bus.writeenable, bus.aluresult);
    end
    bus.regout1 = 8'h00;
    bus.regout2 = 8'h80;
    #1;
    checks++;
    if (bus.aluresult !== 8'h80) begin
      fails++;
      $display("FAIL sub_0x80: got %h want 80", bus.aluresult);
    end
  endtask

  task automatic test_logic_mov;
    logic [31:0] ins [3] = '{32'h0401_0203, 32'h0501_0203, 32'h0101_0203};
    logic [7:0]  exp [3] = '{8'h88, 8'hEE, 8'hAA};
    logic [2:0]  eop [3] = '{3'd2, 3'd3, 3'd0};
    for (int i = 0; i < 3; i++) begin
      capture(ins[i]);
      bus.regout1 = 8'hCC;
      bus.regout2 = 8'hAA;
      #1;
      checks++;
      if ({bus.aluop, bus.writeenable, bus.aluresult} !== {eop[i], 1'b1, exp[i]}) begin
        fails++;
        $display("FAIL logic_mov[%0d]: op=%0d we=%0d res=%h, want op=%0d we=1 res=%h",
                 i, bus.aluop, bus.writeenable, bus.aluresult, eop[i], exp[i]);
      end
    end
  endtask

  task automatic test_illegal;
    capture(32'h0701_0203);
    checks++;
    if ({bus.writeenable, bus.aluop} !== 4'd0) begin
      fails++;
      $display("FAIL illegal: we=%0d op=%0d, want we=0 op=0", bus.writeenable, bus.aluop);
    end
    capture(32'h0201_0203);
    bus.regout1 = 8'h01;
    bus.regout2 = 8'h02;
    #1;
    checks++;
    if ({bus.writeenable, bus.aluop, bus.aluresult} !== {1'b1, 3'd1, 8'h03}) begin
      fails++;
      $display("FAIL after_illegal: we=%0d op=%0d res=%h, want 1 1 03", bus.writeenable, bus.aluop, bus.aluresult);
    end
  endtask

  task automatic test_hold;
    capture(32'h0005_0042);
    #2;
    bus.instruction = 32'h0406_0701;
    #1;
    checks++;
    if ({bus.writereg, bus.aluop, bus.aluresult, bus.writeenable} !== {3'd5, 3'd0, 8'h42, 1'b1}) begin
      fails++;
      $display("FAIL hold: wr=%0d op=%0d res=%h we=%0d, want 5 0 42 1",
               bus.writereg, bus.aluop, bus.aluresult, bus.writeenable);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.writereg, bus.readreg1, bus.readreg2, bus.aluop} !== {3'd6, 3'd7, 3'd1, 3'd2}) begin
      fails++;
      $display("FAIL hold_next: wr=%0d rr1=%0d rr2=%0d op=%0d, want 6 7 1 2",
               bus.writereg, bus.readreg1, bus.readreg2, bus.aluop);
    end
  endtask

  task automatic test_reset_midinstr;
    capture(32'h0203_0102);
    bus.regout1 = 8'h40;
    bus.regout2 = 8'h02;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.writeenable, bus.aluresult, bus.writereg, bus.readreg1} !== 15'd0) begin
      fails++;
      $display("FAIL reset_abort: we=%0d res=%h wr=%0d rr1=%0d, want all 0",
               bus.writeenable, bus.aluresult, bus.writereg, bus.readreg1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.writeenable, bus.aluresult} !== {1'b1, 8'h42}) begin
      fails++;
      $display("FAIL reset_recover: we=%0d res=%h, want 1 42", bus.writeenable, bus.aluresult);
    end
  endtask

  task automatic test_random;
    logic [31:0] ins;
    logic        we;
    logic [2:0]  op;
    logic [7:0]  res;
    for (int i = 0; i < 60; i++) begin
      ins = $urandom;
      ins[31:24] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      capture(ins);
      bus.regout1 = 8'($urandom);
      bus.regout2 = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
      #1;
      model(ins, bus.regout1, bus.regout2, we, op, res);
      checks++;
      if ({bus.readreg1, bus.readreg2, bus.writereg} !== {ins[10:8], ins[2:0], ins[18:16]}) begin
        fails++;
        $display("FAIL rand_addr[%0d]: rr1=%0d rr2=%0d wr=%0d, want %0d %0d %0d",
                 i, bus.readreg1, bus.readreg2, bus.writereg, ins[10:8], ins[2:0], ins[18:16]);
      end
      checks++;
      if ({bus.writeenable, bus.aluop, bus.aluresult} !== {we, op, res}) begin
        fails++;
        $display("FAIL rand_exec[%0d] ins=%h: we=%0d op=%0d res=%h, want we=%0d op=%0d res=%h",
                 i, ins, bus.writeenable, bus.aluop, bus.aluresult, we, op, res);
      end
    end
  endtask

  initial begin
    test_reset;
    test_loadi;
    test_add_sub;
    test_logic_mov;
    test_illegal;
    test_hold;
    test_reset_midinstr;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
